// File: rtl/alu_pkg.sv
// Shared types and widths for the Execute-stage ALU datapath blocks.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
    localparam int ALU_W = 18;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into acc,
// then arithmetic right shift of {acc, mq, q_1}. Purely combinational.
module booth_step #(
    parameter int N = 18
) (
    input  logic [N:0]   i_acc,
    input  logic [N-1:0] i_mq,
    input  logic         i_q_1,
    input  logic [N:0]   i_mcand,
    output logic [N:0]   o_acc,
    output logic [N-1:0] o_mq,
    output logic         o_q_1
);
    logic [N:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_mq[0], i_q_1})
            2'b01:   w_sum = i_acc + i_mcand;
            2'b10:   w_sum = i_acc - i_mcand;
            default: w_sum = i_acc;
        endcase
    end

    assign o_acc = {w_sum[N], w_sum[N:1]};
    assign o_mq  = {w_sum[0], i_mq[N-1:1]};
    assign o_q_1 = i_mq[0];
endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle signed Booth multiplier: N steps per operation, start/busy/done handshake,
// truncated N-bit result with signed overflow flag; car is always 0.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int N  = ALU_W,
    parameter int CW = $clog2(N+1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out,
    output logic         overflow,
    output logic         car
);
    mul_state_t   r_state;
    mul_state_t   w_state_nxt;
    logic [N:0]   r_mcand;
    logic [N:0]   r_acc;
    logic [N-1:0] r_mq;
    logic         r_q_1;
    logic [CW-1:0] r_cnt;
    logic [N-1:0] r_out;
    logic         r_ovf;

    logic [N:0]   w_acc_nxt;
    logic [N-1:0] w_mq_nxt;
    logic         w_q_1_nxt;
    logic         w_last;
    logic [N:0]   w_hi;
    logic         w_ovf;

    booth_step #(.N(N)) u_step (
        .i_acc   (r_acc),
        .i_mq    (r_mq),
        .i_q_1   (r_q_1),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_nxt),
        .o_mq    (w_mq_nxt),
        .o_q_1   (w_q_1_nxt)
    );

    assign w_last = (r_state == CALC) && (r_cnt == CW'(1));
    // Product bits 2N-1..N-1 must be a pure sign extension for the result to fit.
    assign w_hi   = {w_acc_nxt[N-1:0], w_mq_nxt[N-1]};
    assign w_ovf  = !((&w_hi) || (~|w_hi));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_q_1   <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= {A[N-1], A};
                        r_acc   <= '0;
                        r_mq    <= B;
                        r_q_1   <= 1'b0;
                        r_cnt   <= CW'(N);
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    r_q_1 <= w_q_1_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_out <= w_mq_nxt;
                        r_ovf <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign out      = r_out;
    assign overflow = r_ovf;
    assign car      = 1'b0;
endmodule
